// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage ahead of the instruction decoder.
// Holds the program counter and issues one req/ack read at a time to
// instruction memory. Fetched words are buffered in a small FIFO that the
// decoder drains with valid/ready. A redirect flushes the FIFO and restarts
// fetch at a new PC. A request that is still in flight when the redirect
// arrives is allowed to complete, and its data is then thrown away.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // S_DRAIN marks an outstanding request whose returning data must be
    // dropped, so no separate discard flag is needed.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_not_empty;

    assign w_not_empty = (r_count != '0);

    // Only a live (non-draining) request delivers data. A redirect in the
    // same cycle turns that data into discarded data.
    assign w_push = (r_state == S_WAIT) && imem_ack && !redirect;

    // A redirect flushes the FIFO, so any same-cycle pop is ignored.
    assign w_pop = w_not_empty && code_ready && !redirect;

    // A request is issued only from IDLE, so nothing is outstanding at that
    // point. Checking count < DEPTH therefore ensures count + outstanding
    // never exceeds DEPTH.
    assign w_issue = (r_state == S_IDLE) && !halt && !redirect &&
                     (r_count < CNT_W'(DEPTH));

    // Fetch control FSM: PC, request handshake, and draining after a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end else if (redirect) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage. It needs no reset because code_out is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= imem_rdata;
        end
    end

    assign code_valid = w_not_empty;
    assign code_out   = w_not_empty ? r_mem[r_rptr] : '0;
    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign pc_out     = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch.
// The reference model follows the architectural instruction stream: the next
// expected address, the queue of words owed to the decoder, and whether the
// outstanding request has been made stale by a redirect. Directed scenarios
// are followed by a randomized phase.
module tb_instr_fetch;

    localparam int         DEPTH = 2;
    localparam logic [7:0] RPC   = 8'h00;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] code_out;
    logic        code_valid;
    logic        code_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic [7:0]  pc_out;

    logic        mem_ack;
    logic        inj_ack;
    assign imem_ack = mem_ack | inj_ack;

    // Second instance with a non-zero reset PC, used to check wrap-around.
    logic        req_fe;
    logic [7:0]  addr_fe;
    logic [15:0] code_fe;
    logic        valid_fe;
    logic [7:0]  pc_fe;

    instr_fetch u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .pc_out(pc_out)
    );

    instr_fetch #(.RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .reset(reset),
        .imem_req(req_fe), .imem_addr(addr_fe),
        .imem_ack(req_fe), .imem_rdata({8'h10, addr_fe}),
        .code_out(code_fe), .code_valid(valid_fe), .code_ready(1'b1),
        .redirect(1'b0), .redirect_pc(8'h00), .halt(1'b0),
        .pc_out(pc_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] tmem [256];
    int          min_lat = 1;
    int          max_lat = 1;

    // scoreboard / reference model state
    logic [15:0] q[$];
    logic [15:0] got[$];
    logic [7:0]  issued[$];
    logic [7:0]  e_pc;
    logic        stale;
    int          n_issue;
    logic        prev_ok, prev_req, prev_ack, prev_halt, prev_redir;
    logic [7:0]  prev_addr;
    int          prev_q;
    int          fe_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout waiting at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: acks each request after a random latency.
    int lat_cnt = -1;
    always @(posedge clk) begin
        #1;
        if (reset || mem_ack) begin
            mem_ack = 1'b0;
            lat_cnt = -1;
        end else if (imem_req) begin
            if (lat_cnt < 0) lat_cnt = $urandom_range(max_lat, min_lat);
            if (lat_cnt == 0) begin
                mem_ack    = 1'b1;
                imem_rdata = tmem[imem_addr];
            end else begin
                lat_cnt--;
            end
        end
    end

    // Monitor: compare the DUT against the model, then advance the model
    // by what the coming clock edge will do.
    always @(negedge clk) begin
        logic       exp_req;
        logic [7:0] pexp;
        if (reset) begin
            chk("rst_req", 32'(imem_req), 32'(0));
            chk("rst_addr", 32'(imem_addr), 32'(RPC));
            chk("rst_pc", 32'(pc_out), 32'(RPC));
            chk("rst_valid", 32'(code_valid), 32'(0));
            chk("rst_code", 32'(code_out), 32'(0));
            q.delete();
            got.delete();
            issued.delete();
            e_pc    = RPC;
            stale   = 1'b0;
            prev_ok = 1'b0;
            prev_req = 1'b0;
            n_issue = 0;
        end else begin
            chk("valid", 32'(code_valid), 32'(q.size() != 0));
            if (code_valid && q.size() != 0) chk("code_out", 32'(code_out), 32'(q[0]));
            chk("occupancy", 32'((q.size() + int'(imem_req)) <= DEPTH), 32'(1));
            pexp = e_pc + ((imem_req && !stale) ? 8'd1 : 8'd0);
            chk("pc_out", 32'(pc_out), 32'(pexp));
            if (prev_ok) begin
                exp_req = prev_req ? !prev_ack
                                   : (!prev_halt && !prev_redir && prev_q < DEPTH);
                chk("req", 32'(imem_req), 32'(exp_req));
                if (prev_req && !prev_ack) chk("addr_hold", 32'(imem_addr), 32'(prev_addr));
            end
            if (imem_req && !prev_req) begin
                chk("issue_addr", 32'(imem_addr), 32'(e_pc));
                n_issue++;
                issued.push_back(imem_addr);
            end
            prev_ok    = 1'b1;
            prev_req   = imem_req;
            prev_ack   = imem_ack;
            prev_halt  = halt;
            prev_redir = redirect;
            prev_addr  = imem_addr;
            prev_q     = q.size();
            if (redirect) begin
                q.delete();
                e_pc  = redirect_pc;
                stale = imem_req && !imem_ack;
            end else begin
                if (code_valid && code_ready && q.size() != 0) begin
                    got.push_back(code_out);
                    void'(q.pop_front());
                end
                if (imem_req && imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        chk("ack_addr", 32'(imem_addr), 32'(e_pc));
                        q.push_back(tmem[e_pc]);
                        e_pc = e_pc + 8'd1;
                    end
                end
            end
        end
    end

    // Monitor for the RESET_PC=0xFE instance: first requests wrap FE, FF, 00.
    always @(negedge clk) begin
        if (reset) begin
            fe_idx = 0;
        end else if (fe_idx < 4) begin
            if (valid_fe) chk("fe_code_hi", 32'(code_fe[15:8]), 32'(8'h10));
            if (req_fe) begin
                chk("fe_addr", 32'(addr_fe), 32'(8'(8'hFE + fe_idx)));
                chk("fe_pc", 32'(pc_fe), 32'(8'(8'hFF + fe_idx)));
                fe_idx++;
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        halt     = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        int k = 0;
        while (got.size() < n && k < 200) begin
            step();
            k++;
        end
        if (got.size() < n) timeout(name);
    endtask

    task automatic wait_issued(input int n, input string name);
        int k = 0;
        while (issued.size() < n && k < 200) begin
            step();
            k++;
        end
        if (issued.size() < n) timeout(name);
    endtask

    initial begin
        int         k;
        int         n0;
        int         k0;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a       = 8'(i);
            tmem[i] = (i < 128) ? (16'h1000 + {8'h00, a}) : 16'($urandom);
        end
        reset       = 1'b1;
        mem_ack     = 1'b0;
        inj_ack     = 1'b0;
        imem_rdata  = '0;
        code_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;

        // 1: in-order fetch with a fixed one-cycle ack latency
        min_lat = 1; max_lat = 1;
        do_reset();
        wait_got(3, "t1_words");
        if (got.size() >= 3) begin
            for (int i = 0; i < 3; i++) chk("t1_code", 32'(got[i]), 32'(16'h1000 + i));
        end
        if (issued.size() >= 3) begin
            for (int i = 0; i < 3; i++) chk("t1_addr", 32'(issued[i]), 32'(i));
        end

        // 2: decoder stalled -> exactly DEPTH requests, then resume at addr 2
        code_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 15; i++) step();
        chk("t2_issues", 32'(n_issue), 32'(DEPTH));
        chk("t2_req", 32'(imem_req), 32'(0));
        chk("t2_valid", 32'(code_valid), 32'(1));
        chk("t2_code", 32'(code_out), 32'(16'h1000));
        code_ready = 1'b1;
        wait_issued(3, "t2_resume");
        if (issued.size() >= 3) chk("t2_resume_addr", 32'(issued[2]), 32'(2));

        // 3: redirect while the request to 0x03 is pending
        min_lat = 3; max_lat = 3;
        do_reset();
        k = 0;
        while (!(imem_req && imem_addr == 8'h03 && !imem_ack) && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) timeout("t3_pending");
        n0          = got.size();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        wait_got(n0 + 1, "t3_target");
        if (got.size() > n0) chk("t3_first", 32'(got[n0]), 32'(16'h1040));

        // 5: halt while a request is pending
        min_lat = 2; max_lat = 2;
        code_ready = 1'b0;
        do_reset();
        k = 0;
        while (!imem_req && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) timeout("t5_req");
        halt = 1'b1;
        k = 0;
        while (imem_req && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) timeout("t5_done");
        k0 = n_issue;
        for (int i = 0; i < 8; i++) step();
        chk("t5_no_issue", 32'(n_issue), 32'(k0));
        chk("t5_buffered", 32'(code_valid), 32'(1));
        chk("t5_word", 32'(code_out), 32'(16'h1000));
        halt       = 1'b0;
        code_ready = 1'b1;
        wait_issued(k0 + 1, "t5_resume");
        if (issued.size() > k0 && k0 > 0)
            chk("t5_next_addr", 32'(issued[k0]), 32'(8'(issued[k0-1] + 8'd1)));

        // 6: reset asserted mid-WAIT, with a late ack while reset is held
        do_reset();
        k = 0;
        while (!(imem_req && !imem_ack) && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) timeout("t6_wait");
        #1;
        reset = 1'b1;
        #1;
        chk("t6_req", 32'(imem_req), 32'(0));
        chk("t6_valid", 32'(code_valid), 32'(0));
        chk("t6_pc", 32'(pc_out), 32'(RPC));
        chk("t6_addr", 32'(imem_addr), 32'(RPC));
        step();
        inj_ack = 1'b1;
        step();
        inj_ack = 1'b0;
        step();
        reset = 1'b0;
        wait_issued(1, "t6_restart");
        if (issued.size() >= 1) chk("t6_restart_addr", 32'(issued[0]), 32'(RPC));

        // randomized traffic: ready, halt, redirects, and memory latency
        min_lat = 0; max_lat = 3;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            code_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) halt = !halt;
            redirect = ($urandom_range(24, 0) == 0);
            if (redirect) redirect_pc = 8'($urandom);
            step();
        end
        redirect = 1'b0;
        halt     = 1'b0;
        for (int i = 0; i < 10; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
